detector_sentido: RTL

Decodes the two parking-gate photo-sensors (a outer, b inner) into direction events for the occupancy counter. It synchronises and debounces both sensor lines, tracks the full four-phase crossing sequence, and emits a single-cycle x pulse for a completed entry or y pulse for a completed exit. Aborted or illegal sequences never produce x or y. This block is the producer of the x/y interface consumed by `contador`.

---
 rtl/detector_sentido.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/detector_sentido.sv
// detector_sentido: parking-gate direction decoder.
// Sync, debounce, four-phase crossing FSM -> x/y/err pulses.
module detector_sentido #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic x,
    output logic y,
    output logic err,
    output logic busy
);

    localparam int CW = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        E1,
        E2,
        E3,
        X1,
        X2,
        X3,
        ERR
    } state_t;

    logic a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic a_s1_d, a_s2_d, b_s1_d, b_s2_d;

    logic          ad_q, bd_q, ad_d, bd_d;
    logic [CW-1:0] acnt_q, bcnt_q, acnt_d, bcnt_d;

    state_t state_q, state_d;
    logic   x_q, y_q, err_q, busy_q;
    logic   x_d, y_d, err_d, busy_d;
    logic [1:0] ab;

    // Two-flop synchroniser inputs for both sensor lines
    always_comb begin
        a_s1_d = a;
        a_s2_d = a_s1_q;
        b_s1_d = b;
        b_s2_d = b_s1_q;
    end

    // Per-channel debounce: db follows s2 after DEB_CYCLES of disagreement
    always_comb begin
        ad_d   = ad_q;
        acnt_d = '0;
        if (a_s2_q != ad_q) begin
            if (acnt_q == CNT_MAX) begin
                ad_d = a_s2_q;
            end else begin
                acnt_d = acnt_q + CW'(1);
            end
        end
        bd_d   = bd_q;
        bcnt_d = '0;
        if (b_s2_q != bd_q) begin
            if (bcnt_q == CNT_MAX) begin
                bd_d = b_s2_q;
            end else begin
                bcnt_d = bcnt_q + CW'(1);
            end
        end
    end

    assign ab = {ad_q, bd_q};

    // Crossing FSM next state and pulse decode on debounced {a,b}
    always_comb begin
        state_d = state_q;
        x_d     = 1'b0;
        y_d     = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                case (ab)
                    2'b10:   state_d = E1;
                    2'b01:   state_d = X1;
                    2'b11:   state_d = ERR;
                    default: state_d = IDLE;
                endcase
            end
            E1: begin
                case (ab)
                    2'b11:   state_d = E2;
                    2'b00:   state_d = IDLE;
                    2'b01:   state_d = ERR;
                    default: state_d = E1;
                endcase
            end
            E2: begin
                case (ab)
                    2'b01:   state_d = E3;
                    2'b10:   state_d = E1;
                    2'b00:   state_d = ERR;
                    default: state_d = E2;
                endcase
            end
            E3: begin
                case (ab)
                    2'b00: begin
                        state_d = IDLE;
                        x_d     = 1'b1;
                    end
                    2'b11:   state_d = E2;
                    2'b10:   state_d = ERR;
                    default: state_d = E3;
                endcase
            end
            X1: begin
                case (ab)
                    2'b11:   state_d = X2;
                    2'b00:   state_d = IDLE;
                    2'b10:   state_d = ERR;
                    default: state_d = X1;
                endcase
            end
            X2: begin
                case (ab)
                    2'b10:   state_d = X3;
                    2'b01:   state_d = X1;
                    2'b00:   state_d = ERR;
                    default: state_d = X2;
                endcase
            end
            X3: begin
                case (ab)
                    2'b00: begin
                        state_d = IDLE;
                        y_d     = 1'b1;
                    end
                    2'b11:   state_d = X2;
                    2'b01:   state_d = ERR;
                    default: state_d = X3;
                endcase
            end
            ERR: begin
                if (ab == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == ERR && state_q != ERR) begin
            err_d = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    // All state and registered outputs; reset clears everything
    always_ff @(posedge clk) begin
        if (reset) begin
            a_s1_q  <= 1'b0;
            a_s2_q  <= 1'b0;
            b_s1_q  <= 1'b0;
            b_s2_q  <= 1'b0;
            ad_q    <= 1'b0;
            bd_q    <= 1'b0;
            acnt_q  <= '0;
            bcnt_q  <= '0;
            state_q <= IDLE;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            a_s1_q  <= a_s1_d;
            a_s2_q  <= a_s2_d;
            b_s1_q  <= b_s1_d;
            b_s2_q  <= b_s2_d;
            ad_q    <= ad_d;
            bd_q    <= bd_d;
            acnt_q  <= acnt_d;
            bcnt_q  <= bcnt_d;
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule
